// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU: buffers {op,a,b} commands in a FIFO, drives
// the ALU operand registers, then returns each sampled result on a valid/ready channel.
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sw_clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [2:0]       alu_select,
   input  logic [5:0]       alu_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [5:0]       rsp_data,
   output logic [2:0]       rsp_op,
   output logic             busy,
   output logic [CNT_W-1:0] done_count,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens at a rising edge where valid && ready are both
   // high; valid, once raised, holds its payload stable until that transfer.

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [10:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [10:0] head;
   logic        full, empty, push, pop, capture, hs;

   // Extra MSB on the pointers separates full from empty.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full && !sw_clr;
   assign hs        = rsp_valid && rsp_ready;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign busy      = !empty || (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            capture   = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            if (hs) begin
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = DRIVE;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Flush overrides everything; gating pop keeps the ALU registers untouched.
      if (sw_clr) begin
         state_nxt = IDLE;
         pop       = 1'b0;
         capture   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (sw_clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_select <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_op     <= '0;
         done_count <= '0;
      end else begin
         if (pop) begin
            alu_select <= head[10:8];
            alu_a      <= head[7:4];
            alu_b      <= head[3:0];
         end
         if (sw_clr) begin
            rsp_valid <= 1'b0;
         end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_op    <= alu_select;
         end else if (hs) begin
            rsp_valid <= 1'b0;
         end
         if (hs && !sw_clr) done_count <= done_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
